// File: rtl/prep_pkg.sv
// prep_pkg: shared width default and channel index definitions for the prep1 receive path
package prep_pkg;
    localparam int DEF_WIDTH = 8;
    typedef logic [1:0] ch_t;
    localparam ch_t CH0 = 2'd0;
    localparam ch_t CH1 = 2'd1;
    localparam ch_t CH2 = 2'd2;
    localparam ch_t CH3 = 2'd3;
endpackage

// File: rtl/prep1_deser.sv
// prep1_deser: MSB-first serial-to-byte deserialiser with frame resync and one-deep hand-off
module prep1_deser
    import prep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_l,
    input  logic             sin,
    input  logic             frm,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] hold,
    output ch_t              dest,
    output logic             wr_pend,
    output logic             busy
);
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;

    assign busy = cnt != '0;

    // Shift in bits, resync on FRM, and hand a completed byte plus its destination to the write stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            cnt     <= '0;
            hold    <= '0;
            dest    <= CH0;
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (s_l) begin
                sr  <= {sr[WIDTH-2:0], sin};
                cnt <= frm ? CNT_W'(1) : cnt + 1'b1;
                if (!frm && cnt == CNT_W'(WIDTH - 1)) begin
                    hold    <= {sr[WIDTH-2:0], sin};
                    dest    <= {s1, s0};
                    wr_pend <= 1'b1;
                end
            end else if (frm) begin
                sr  <= '0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/prep1_distrib.sv
// prep1_distrib: receives a serial byte stream and demultiplexes each byte to one of four valid-flagged registers
module prep1_distrib
    import prep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             S_L,
    input  logic             SIN,
    input  logic             FRM,
    input  logic             S1,
    input  logic             S0,
    input  logic [3:0]       CLR,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [3:0]       V,
    output logic             OVR,
    output logic             BUSY
);
    logic [WIDTH-1:0] hold;
    ch_t              dest;
    logic             wr_pend;
    logic [WIDTH-1:0] q [4];
    logic [3:0]       wr_mask;

    prep1_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_deser (
        .clk     (CLK),
        .rst_n   (RST_N),
        .s_l     (S_L),
        .sin     (SIN),
        .frm     (FRM),
        .s1      (S1),
        .s0      (S0),
        .hold    (hold),
        .dest    (dest),
        .wr_pend (wr_pend),
        .busy    (BUSY)
    );

    assign wr_mask = wr_pend ? 4'b0001 << dest : 4'b0000;
    assign Q0 = q[CH0];
    assign Q1 = q[CH1];
    assign Q2 = q[CH2];
    assign Q3 = q[CH3];

    // Write the held byte to its channel; a same-edge write beats a clear, and overwriting an uncleared valid channel latches OVR
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) q[i] <= '0;
            V   <= '0;
            OVR <= 1'b0;
        end else begin
            V <= (V & ~CLR) | wr_mask;
            if (wr_pend) begin
                q[dest] <= hold;
                if (V[dest] && !CLR[dest]) OVR <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prep1_distrib.sv
// tb_prep1_distrib: directed and randomized checks of prep1_distrib against a byte-level reference model
module tb_prep1_distrib;
    logic       CLK = 0, RST_N = 0, S_L = 0, SIN = 0, FRM = 0, S1 = 0, S0 = 0;
    logic [3:0] CLR = 0;
    logic [7:0] Q0, Q1, Q2, Q3;
    logic [3:0] V;
    logic       OVR, BUSY;
    int checks = 0, errors = 0;

    logic [7:0] m_q [4];
    logic [3:0] m_v;
    logic       m_ovr, m_pend;
    logic [7:0] m_pbyte;
    int         m_bits, m_val, m_pdest;

    prep1_distrib dut (
        .CLK(CLK), .RST_N(RST_N), .S_L(S_L), .SIN(SIN), .FRM(FRM), .S1(S1), .S0(S0),
        .CLR(CLR), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .V(V), .OVR(OVR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_q[i] = 0;
        m_v = 0; m_ovr = 0; m_pend = 0; m_pbyte = 0;
        m_bits = 0; m_val = 0; m_pdest = 0;
    endtask

    task automatic model_edge();
        if (m_pend) begin
            if (m_v[m_pdest] && !CLR[m_pdest]) m_ovr = 1;
            m_q[m_pdest] = m_pbyte;
        end
        m_v = m_v & ~CLR;
        if (m_pend) m_v[m_pdest] = 1;
        m_pend = 0;
        if (S_L) begin
            if (FRM) begin
                m_bits = 1;
                m_val  = int'(SIN);
            end else begin
                m_val  = (m_val * 2 + int'(SIN)) % 256;
                m_bits = m_bits + 1;
                if (m_bits == 8) begin
                    m_pend  = 1;
                    m_pbyte = 8'(m_val);
                    m_pdest = int'(S1) * 2 + int'(S0);
                    m_bits  = 0;
                    m_val   = 0;
                end
            end
        end else if (FRM) begin
            m_bits = 0;
            m_val  = 0;
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_eq("q0", Q0, m_q[0]);
        check_eq("q1", Q1, m_q[1]);
        check_eq("q2", Q2, m_q[2]);
        check_eq("q3", Q3, m_q[3]);
        check_eq("v", V, m_v);
        check_eq("ovr", OVR, m_ovr);
        check_eq("busy", BUSY, m_bits != 0);
    endtask

    task automatic idle(input int n, input logic [3:0] clr);
        for (int k = 0; k < n; k++) begin
            S_L = 0; FRM = 0; CLR = clr;
            cycle();
        end
        CLR = 0;
    endtask

    task automatic shift_bits(input int n);
        for (int k = 0; k < n; k++) begin
            S_L = 1; FRM = 0; CLR = 0; SIN = 1'($urandom);
            {S1, S0} = 2'($urandom);
            cycle();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] sel, input bit frm_first,
                             input int pause_at, input int pause_len);
        for (int i = 7; i >= 0; i--) begin
            if (i == pause_at) idle(pause_len, 4'b0000);
            S_L = 1; CLR = 0; SIN = b[i];
            FRM = frm_first && (i == 7);
            {S1, S0} = (i == 0) ? sel : 2'($urandom);
            cycle();
        end
        FRM = 0;
    endtask

    task automatic do_reset();
        #2 RST_N = 0;
        model_reset();
        #1;
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_v", V, 0);
        check_eq("rst_q0", Q0, 0);
        check_eq("rst_ovr", OVR, 0);
        #1 RST_N = 1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_eq("init_q2", Q2, 0);
        check_eq("init_v", V, 0);
        check_eq("init_busy", BUSY, 0);
        RST_N = 1;

        // reset mid-byte then a clean byte to channel 2
        shift_bits(5);
        check_eq("mid_busy", BUSY, 1);
        do_reset();
        send_byte(8'hA5, 2'b10, 0, -1, 0);
        idle(1, 4'b0000);
        check_eq("rm_q2", Q2, 8'hA5);
        check_eq("rm_v", V, 4'b0100);
        check_eq("rm_q0", Q0, 0);
        check_eq("rm_q1", Q1, 0);
        check_eq("rm_q3", Q3, 0);

        // back-to-back bytes to all four channels
        do_reset();
        send_byte(8'h11, 2'b00, 0, -1, 0);
        send_byte(8'h22, 2'b01, 0, -1, 0);
        send_byte(8'h33, 2'b10, 0, -1, 0);
        send_byte(8'h44, 2'b11, 0, -1, 0);
        idle(1, 4'b0000);
        check_eq("b2b_q0", Q0, 8'h11);
        check_eq("b2b_q1", Q1, 8'h22);
        check_eq("b2b_q2", Q2, 8'h33);
        check_eq("b2b_q3", Q3, 8'h44);
        check_eq("b2b_v", V, 4'b1111);
        check_eq("b2b_ovr", OVR, 0);

        // overrun with no clear
        do_reset();
        send_byte(8'h5A, 2'b01, 0, -1, 0);
        send_byte(8'hC3, 2'b01, 0, -1, 0);
        idle(1, 4'b0000);
        check_eq("ov_q1", Q1, 8'hC3);
        check_eq("ov_v1", V[1], 1);
        check_eq("ov_ovr", OVR, 1);

        // clear between the bytes prevents overrun
        do_reset();
        send_byte(8'h5A, 2'b01, 0, -1, 0);
        idle(1, 4'b0000);
        idle(1, 4'b0010);
        send_byte(8'hC3, 2'b01, 0, -1, 0);
        idle(1, 4'b0000);
        check_eq("noov_q1", Q1, 8'hC3);
        check_eq("noov_ovr", OVR, 0);

        // clear colliding with a write: write wins, next clear takes effect
        do_reset();
        send_byte(8'h7E, 2'b11, 0, -1, 0);
        idle(1, 4'b1000);
        check_eq("col_v3", V[3], 1);
        check_eq("col_q3", Q3, 8'h7E);
        idle(1, 4'b1000);
        check_eq("col_v3_clr", V[3], 0);
        check_eq("col_q3_hold", Q3, 8'h7E);

        // resync drops a partial byte, pause mid-byte, FRM with the first bit
        do_reset();
        shift_bits(3);
        S_L = 0; FRM = 1; CLR = 0;
        cycle();
        FRM = 0;
        check_eq("frm_busy", BUSY, 0);
        send_byte(8'h81, 2'b00, 0, 3, 4);
        idle(1, 4'b0000);
        check_eq("pause_q0", Q0, 8'h81);
        shift_bits(3);
        send_byte(8'hFF, 2'b01, 1, -1, 0);
        idle(1, 4'b0000);
        check_eq("frm_q1", Q1, 8'hFF);
        check_eq("frm_q0", Q0, 8'h81);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            S_L = ($urandom_range(0, 9) < 8);
            SIN = 1'($urandom);
            FRM = ($urandom_range(0, 19) == 0);
            {S1, S0} = 2'($urandom);
            for (int c = 0; c < 4; c++) CLR[c] = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
